// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage sequencer: load/store/push/pop over a req/ack data port
// Owns the stack pointer and stalls the pipeline until each access completes, faults or times out.
module mem_stage_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] SP_INIT  = '1,
  parameter logic [ADDR_W-1:0] SP_LIMIT = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push_signal,
  input  logic              pop_signal,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic [ADDR_W-1:0] sp_out,
  output logic              fault,
  output logic [1:0]        fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            r_state, w_next;
  op_t               r_op, w_op;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_sp;
  logic              w_any, w_multi, w_timeout, w_start, w_fault;
  logic [1:0]        w_code;

  assign w_any     = mem_read | mem_write | push_signal | pop_signal;
  assign w_multi   = ($countones({mem_read, mem_write, push_signal, pop_signal}) > 1);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  assign w_op      = push_signal ? OP_PUSH : pop_signal ? OP_POP : mem_write ? OP_STORE : OP_LOAD;
  assign sp_out    = r_sp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_fault = 1'b0;
    w_code  = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && w_any) begin
          w_next = S_DONE;
          if (w_multi) begin
            w_fault = 1'b1;
            w_code  = 2'd0;
          end else if (push_signal && r_sp == SP_LIMIT) begin
            w_fault = 1'b1;
            w_code  = 2'd1;
          end else if (pop_signal && r_sp == SP_INIT) begin
            w_fault = 1'b1;
            w_code  = 2'd2;
          end else begin
            w_next  = S_ACCESS;
            w_start = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next  = S_DONE;
          w_fault = 1'b1;
          w_code  = 2'd3;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if ((r_state == S_IDLE && req_valid && w_any) || r_state == S_ACCESS) stall = 1'b1;
  end

  // Port fields are loaded only on entry to ACCESS so they stay stable until ack or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= SP_INIT;
      r_cnt       <= '0;
      r_op        <= OP_LOAD;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'd0;
    end else begin
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      if (w_fault) begin
        fault      <= 1'b1;
        fault_code <= w_code;
      end
      if (w_start) begin
        dmem_req   <= 1'b1;
        r_cnt      <= '0;
        r_op       <= w_op;
        dmem_we    <= (w_op == OP_STORE) || (w_op == OP_PUSH);
        dmem_wdata <= wdata_in;
        dmem_addr  <= (w_op == OP_PUSH) ? r_sp : (w_op == OP_POP) ? r_sp + ONE : addr_in;
      end
      if (r_state == S_ACCESS) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          if (r_op == OP_LOAD || r_op == OP_POP) begin
            rdata_out   <= dmem_rdata;
            rdata_valid <= 1'b1;
          end
          if (r_op == OP_PUSH) r_sp <= r_sp - ONE;
          if (r_op == OP_POP)  r_sp <= r_sp + ONE;
        end else if (w_timeout) begin
          dmem_req <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam logic [15:0] LIMIT = 16'hFFFD;
  localparam logic [15:0] INIT  = 16'hFFFF;
  localparam int          TO    = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        push_signal = 1'b0, pop_signal = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0, dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, stall, rdata_valid, fault;
  logic [15:0] dmem_addr, dmem_wdata, rdata_out, sp_out;
  logic [1:0]  fault_code;

  mem_stage_ctrl #(
    .ADDR_W(16), .DATA_W(16), .SP_INIT(INIT), .SP_LIMIT(LIMIT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .push_signal(push_signal), .pop_signal(pop_signal),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .sp_out(sp_out), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } mem_t;
  typedef struct { logic flt; logic [1:0] code; logic rv; logic [15:0] rdata; logic [15:0] sp; } res_t;

  mem_t mem_q[$];
  res_t res_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_sp = INIT;
  logic [15:0] m_rdata = '0;
  logic prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dmem_req && !prev_req) begin
      if (mem_q.size() == 0) check("unexpected_req", 1, 0);
      else begin
        mem_t m;
        m = mem_q.pop_front();
        check("mem_we", dmem_we, m.we);
        check("mem_addr", dmem_addr, m.addr);
        if (m.we) check("mem_wdata", dmem_wdata, m.wdata);
      end
    end
    if (fault || rdata_valid) begin
      if (res_q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        res_t r;
        r = res_q.pop_front();
        check("fault", fault, r.flt);
        if (r.flt) check("fault_code", fault_code, r.code);
        check("rdata_valid", rdata_valid, r.rv);
        check("rdata_out", rdata_out, r.rdata);
        check("sp_done", sp_out, r.sp);
      end
    end
    prev_req <= dmem_req;
  end

  task automatic do_op(input logic rd, input logic wr, input logic ps, input logic pp,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input int ack_at, input logic [15:0] rdata);
    int nops, exp_stall, exp_req, n_stall, n_req;
    logic done;
    nops = int'(rd) + int'(wr) + int'(ps) + int'(pp);
    exp_req = 0;
    exp_stall = 1;
    if (nops > 1)                 res_q.push_back('{1'b1, 2'd0, 1'b0, m_rdata, m_sp});
    else if (ps && m_sp == LIMIT) res_q.push_back('{1'b1, 2'd1, 1'b0, m_rdata, m_sp});
    else if (pp && m_sp == INIT)  res_q.push_back('{1'b1, 2'd2, 1'b0, m_rdata, m_sp});
    else begin
      mem_q.push_back('{wr | ps, ps ? m_sp : pp ? m_sp + 16'd1 : addr, wdata});
      if (ack_at == 0) begin
        exp_req = TO;
        exp_stall = TO + 1;
        res_q.push_back('{1'b1, 2'd3, 1'b0, m_rdata, m_sp});
      end else begin
        exp_req = ack_at;
        exp_stall = ack_at + 1;
        if (ps) m_sp = m_sp - 16'd1;
        if (pp) m_sp = m_sp + 16'd1;
        if (rd || pp) begin
          m_rdata = rdata;
          res_q.push_back('{1'b0, 2'd0, 1'b1, m_rdata, m_sp});
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; push_signal = ps; pop_signal = pp;
    addr_in = addr; wdata_in = wdata;
    n_stall = 0;
    n_req = 0;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        n_stall++;
        if (dmem_req) n_req++;
        dmem_ack = (n_req == ack_at) && dmem_req;
        dmem_rdata = rdata;
      end else done = 1'b1;
    end
    if (!done) check("stall_bound", 1, 0);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; push_signal = 1'b0; pop_signal = 1'b0;
    dmem_ack = 1'b0;
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", n_req, exp_req);
    check("sp_after", sp_out, m_sp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_flags", {fault, rdata_valid, fault_code, stall}, 0);
    check("rst_sp", sp_out, INIT);
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(1, 0, 0, 0, 16'h0040, 16'h0000, 2, 16'hBEEF);
    do_op(0, 0, 1, 0, 16'h0000, 16'h1234, 1, 16'h0000);
    do_op(0, 0, 0, 1, 16'h0000, 16'h0000, 3, 16'h1234);
    do_op(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 16'h0000);
    do_op(0, 0, 1, 0, 16'h0000, 16'hAAAA, 1, 16'h0000);
    do_op(0, 0, 1, 0, 16'h0000, 16'hBBBB, 2, 16'h0000);
    do_op(0, 0, 1, 0, 16'h0000, 16'hCCCC, 1, 16'h0000);
    do_op(0, 1, 0, 0, 16'h0100, 16'h5555, 0, 16'h0000);
    do_op(1, 0, 0, 0, 16'h0200, 16'h0000, 1, 16'h5A5A);
    do_op(1, 0, 1, 0, 16'h0300, 16'h0000, 1, 16'h0000);
    do_op(0, 1, 0, 0, 16'h0400, 16'h6666, 4, 16'h0000);
    do_op(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 16'hBBBB);

    // stray ack while idle must be ignored
    @(posedge clk);
    #1 dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_stall", stall, 0);
    check("idle_ack_sp", sp_out, m_sp);
    dmem_ack = 1'b0;

    // reset in the middle of a push access
    @(posedge clk);
    #1;
    req_valid = 1'b1; push_signal = 1'b1; wdata_in = 16'h7777;
    mem_q.push_back('{1'b1, m_sp, 16'h7777});
    @(posedge clk);
    @(negedge clk);
    check("mid_req", dmem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_drop_req", dmem_req, 0);
    check("rst_sp_kept", sp_out, INIT);
    req_valid = 1'b0; push_signal = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    m_sp = INIT;
    m_rdata = '0;

    do_op(1, 0, 0, 0, 16'h0050, 16'h0000, 2, 16'hC0DE);

    repeat (2) @(negedge clk);
    check("mem_q_empty", mem_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
